// File: rtl/treeval_pkg.sv
// Shared tree evaluator constants: widths, node word field slices and
// loader state encoding. Imported by the loader, its unpacker and interface.
package treeval_pkg;

    localparam int W_ADDR        = 10;
    localparam int W_ACTION      = 3;
    localparam int W_REWARD      = 12;
    localparam int W_WEIGHT      = 7;
    localparam int NODE_SIZE     = 32;
    localparam int MAX_NUM_NODES = 1024;

    localparam int PARENT_HI = 31;
    localparam int PARENT_LO = 22;
    localparam int ACTION_HI = 21;
    localparam int ACTION_LO = 19;
    localparam int REWARD_HI = 18;
    localparam int REWARD_LO = 7;
    localparam int WEIGHT_HI = 6;
    localparam int WEIGHT_LO = 0;

    localparam int MAX_WEIGHT = 100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONF,
        S_FETCH,
        S_PAR,
        S_ACT,
        S_REW,
        S_WGT,
        S_DONE
    } loader_state_e;

endpackage

// File: rtl/tree_loader_if.sv
// Node word stream into the loader: valid/ready handshake with 32-bit data.
// master: host/DMA side (drives valid, data); slave: loader (drives ready).
interface tree_loader_if;
    import treeval_pkg::*;

    logic                 in_valid;
    logic [NODE_SIZE-1:0] in_data;
    logic                 in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/tree_node_unpack.sv
// Combinational split of a packed node word into parent/action/reward/weight
// plus validity flags. Ports: word, addr in; fields, weight_bad, parent_bad out.
module tree_node_unpack
    import treeval_pkg::*;
(
    input  logic [NODE_SIZE-1:0] word,
    input  logic [W_ADDR-1:0]    addr,
    output logic [W_ADDR-1:0]    parent,
    output logic [W_ACTION-1:0]  action,
    output logic [W_REWARD-1:0]  reward,
    output logic [W_WEIGHT-1:0]  weight,
    output logic                 weight_bad,
    output logic                 parent_bad
);

    assign parent = word[PARENT_HI:PARENT_LO];
    assign action = word[ACTION_HI:ACTION_LO];
    assign reward = word[REWARD_HI:REWARD_LO];
    assign weight = word[WEIGHT_HI:WEIGHT_LO];

    assign weight_bad = weight > W_WEIGHT'(MAX_WEIGHT);

    // The root has no predecessor; every other parent must come earlier.
    assign parent_bad = (addr != '0) && (parent >= addr);

endmodule

// File: rtl/tree_loader.sv
// Loads node count and node words into the tree evaluator over mem_*/conf_*.
// Ports: clk, rst, start, node_count, node_in (slave stream), mem_* strobes,
// mem_addr, mem_data, conf_nodes, conf_data, busy, done, err.
// Optional TREE_LOADER_VALIDATE_EN: reject bad weight/parent words.
module tree_loader #(
    parameter int W_ADDR = 10,
    parameter int W_DATA = 12,
    parameter int W_CONF = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_CONF-1:0] node_count,
    tree_loader_if.slave      node_in,
    output logic              mem_par,
    output logic              mem_act,
    output logic              mem_rew,
    output logic              mem_weight,
    output logic [W_ADDR-1:0] mem_addr,
    output logic [W_DATA-1:0] mem_data,
    output logic              conf_nodes,
    output logic [W_CONF-1:0] conf_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import treeval_pkg::loader_state_e;
    import treeval_pkg::S_IDLE, treeval_pkg::S_CONF, treeval_pkg::S_FETCH;
    import treeval_pkg::S_PAR, treeval_pkg::S_ACT, treeval_pkg::S_REW;
    import treeval_pkg::S_WGT, treeval_pkg::S_DONE;

    localparam int NW = treeval_pkg::NODE_SIZE;

    loader_state_e state_q, state_d;

    logic [W_CONF-1:0] count_q, count_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [NW-1:0]     word_q, word_d;
    logic [NW-1:0]     word_sel;
    logic              in_ready_q;
    logic              take;
    logic              last_node;
    logic              node_bad;
    logic              err_d;
    logic              strobe_d;
    logic [W_DATA-1:0] field_d;

    logic [treeval_pkg::W_ADDR-1:0]   f_parent;
    logic [treeval_pkg::W_ACTION-1:0] f_action;
    logic [treeval_pkg::W_REWARD-1:0] f_reward;
    logic [treeval_pkg::W_WEIGHT-1:0] f_weight;
    logic                             weight_bad;
    logic                             parent_bad;

    assign node_in.in_ready = in_ready_q;
    assign take = node_in.in_valid & in_ready_q;

    // Outputs are registered from the next state, so the PAR write is
    // prepared while the word is still on the bus.
    assign word_sel = (state_q == S_FETCH) ? node_in.in_data : word_q;

    assign last_node = addr_q == W_ADDR'(count_q - W_CONF'(1));

    tree_node_unpack u_unpack (
        .word       (word_sel),
        .addr       (addr_q),
        .parent     (f_parent),
        .action     (f_action),
        .reward     (f_reward),
        .weight     (f_weight),
        .weight_bad (weight_bad),
        .parent_bad (parent_bad)
    );

`ifdef TREE_LOADER_VALIDATE_EN
    assign node_bad = weight_bad | parent_bad;
`else
    logic unused_flags;
    assign unused_flags = weight_bad | parent_bad;
    assign node_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        word_d  = word_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (node_count >= W_CONF'(2)) begin
                        count_d = node_count;
                        addr_d  = '0;
                        state_d = S_CONF;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CONF:  state_d = S_FETCH;
            S_FETCH: begin
                if (take) begin
                    word_d = node_in.in_data;
                    if (node_bad) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PAR;
                    end
                end
            end
            S_PAR: state_d = S_ACT;
            S_ACT: state_d = S_REW;
            S_REW: state_d = S_WGT;
            S_WGT: begin
                if (last_node) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + W_ADDR'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        field_d  = '0;
        strobe_d = 1'b0;
        unique case (state_d)
            S_PAR: begin
                field_d  = W_DATA'(f_parent);
                strobe_d = 1'b1;
            end
            S_ACT: begin
                field_d  = W_DATA'(f_action);
                strobe_d = 1'b1;
            end
            S_REW: begin
                field_d  = W_DATA'(f_reward);
                strobe_d = 1'b1;
            end
            S_WGT: begin
                field_d  = W_DATA'(f_weight);
                strobe_d = 1'b1;
            end
            default: begin
                field_d  = '0;
                strobe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            in_ready_q <= 1'b0;
            mem_par    <= 1'b0;
            mem_act    <= 1'b0;
            mem_rew    <= 1'b0;
            mem_weight <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            conf_nodes <= 1'b0;
            conf_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            in_ready_q <= state_d == S_FETCH;
            mem_par    <= state_d == S_PAR;
            mem_act    <= state_d == S_ACT;
            mem_rew    <= state_d == S_REW;
            mem_weight <= state_d == S_WGT;
            conf_nodes <= state_d == S_CONF;
            busy       <= state_d != S_IDLE;
            done       <= state_d == S_DONE;
            err        <= err_d;
            if (state_d == S_CONF) begin
                conf_data <= count_d;
            end
            if (strobe_d) begin
                mem_addr <= addr_q;
                mem_data <= field_d;
            end
        end
    end

endmodule

// File: tb/tb_tree_loader.sv
// Self-checking bench for tree_loader: scoreboard of expected sideband
// writes compared against writes captured from the DUT.
module tb_tree_loader;

    typedef struct packed {
        logic [2:0]  kind;
        logic [9:0]  addr;
        logic [11:0] data;
    } wr_t;

    localparam logic [2:0] K_PAR = 3'd0;
    localparam logic [2:0] K_ACT = 3'd1;
    localparam logic [2:0] K_REW = 3'd2;
    localparam logic [2:0] K_WGT = 3'd3;
    localparam logic [2:0] K_CNF = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  node_count;
    logic        mem_par, mem_act, mem_rew, mem_weight;
    logic [9:0]  mem_addr;
    logic [11:0] mem_data;
    logic        conf_nodes;
    logic [9:0]  conf_data;
    logic        busy, done, err;

    tree_loader_if bus ();

    tree_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .node_count (node_count),
        .node_in    (bus),
        .mem_par    (mem_par),
        .mem_act    (mem_act),
        .mem_rew    (mem_rew),
        .mem_weight (mem_weight),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .conf_nodes (conf_nodes),
        .conf_data  (conf_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   e_cyc = 0;
    wr_t  exp_q[$];
    wr_t  obs_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   err_cnt = 0;
    int   busy_cnt = 0;
    int   multi = 0;

    function automatic wr_t mk(input logic [2:0] k, input int a, input int d);
        wr_t w;
        w.kind = k;
        w.addr = 10'(a);
        w.data = 12'(d);
        return w;
    endfunction

    function automatic void push_node(input int a, input int p, input int ac,
                                      input int rw, input int wt);
        exp_q.push_back(mk(K_PAR, a, p));
        exp_q.push_back(mk(K_ACT, a, ac));
        exp_q.push_back(mk(K_REW, a, rw));
        exp_q.push_back(mk(K_WGT, a, wt));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (conf_nodes) obs_q.push_back(mk(K_CNF, 0, int'(conf_data)));
        if (mem_par)    obs_q.push_back(mk(K_PAR, int'(mem_addr), int'(mem_data)));
        if (mem_act)    obs_q.push_back(mk(K_ACT, int'(mem_addr), int'(mem_data)));
        if (mem_rew)    obs_q.push_back(mk(K_REW, int'(mem_addr), int'(mem_data)));
        if (mem_weight) obs_q.push_back(mk(K_WGT, int'(mem_addr), int'(mem_data)));
        if ($countones({conf_nodes, mem_par, mem_act, mem_rew, mem_weight}) > 1)
            multi++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err)  err_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic do_start(input int c);
        @(negedge clk);
        start = 1'b1;
        node_count = 10'(c);
        @(negedge clk);
        start = 1'b0;
        e_cyc = cyc;
    endtask

    task automatic send(input logic [31:0] w, input int gap, input int hold);
        int n = 0;
        @(negedge clk);
        if (gap == 0) begin
            bus.in_valid = 1'b1;
            bus.in_data = w;
        end
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, want high", n);
        end
        for (int i = 0; i < gap; i++) begin
            tests++;
            if ({bus.in_ready, mem_par, mem_act, mem_rew, mem_weight} !== 5'b10000
                || mem_addr !== 10'(hold)) begin
                fails++;
                $display("FAIL stall_%0d: rdy/strb %b addr %h, want 10000 addr %h",
                         i, {bus.in_ready, mem_par, mem_act, mem_rew, mem_weight},
                         mem_addr, hold);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data = w;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n = 0;
        while (done_cnt == d0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no done after %0d cycles", nm, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.in_ready, mem_par, mem_act, mem_rew, mem_weight, mem_addr,
             mem_data, conf_nodes, conf_data, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {bus.in_ready, mem_par, mem_act, mem_rew, mem_weight,
                      mem_addr, mem_data, conf_nodes, conf_data, busy, done, err});
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, bus.in_ready} !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle: busy/rdy %b, want 00", {busy, bus.in_ready});
        end
    endtask

    task automatic test_basic();
        int ob = obs_q.size();
        int d0 = done_cnt;
        int m0 = multi;
        int idx = 0;
        wr_t e;
        exp_q.delete();
        exp_q.push_back(mk(K_CNF, 0, 3));
        push_node(0, 0, 0, 0, 0);
        push_node(1, 0, 1, 12'h012, 7'h64);
        push_node(2, 0, 2, 12'h1FE, 7'h32);
        do_start(3);
        send(32'h00000000, 0, 0);
        send(32'h00080964, 0, 0);
        send(32'h0010FF32, 0, 0);
        wait_done(d0, "basic");
        tests++;
        if (obs_q.size() - ob !== exp_q.size()) begin
            fails++;
            $display("FAIL basic_count: got %0d writes, want %0d",
                     obs_q.size() - ob, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (ob + idx < obs_q.size()) begin
                tests++;
                if (obs_q[ob + idx] !== e) begin
                    fails++;
                    $display("FAIL basic_wr%0d: got k%0d a%h d%h, want k%0d a%h d%h",
                             idx, obs_q[ob + idx].kind, obs_q[ob + idx].addr,
                             obs_q[ob + idx].data, e.kind, e.addr, e.data);
                end
            end
            idx++;
        end
        tests++;
        if (done_cyc !== e_cyc + 16 || done_cnt - d0 !== 1) begin
            fails++;
            $display("FAIL basic_done: cycle %0d count %0d, want %0d count 1",
                     done_cyc - e_cyc + 1, done_cnt - d0, 17);
        end
        tests++;
        if (multi !== m0) begin
            fails++;
            $display("FAIL basic_onehot: %0d multi-strobe cycles, want 0", multi - m0);
        end
        tests++;
        if ({busy, bus.in_ready} !== 2'b00) begin
            fails++;
            $display("FAIL basic_idle: busy/rdy %b, want 00", {busy, bus.in_ready});
        end
    endtask

    task automatic test_all_ones();
        int ob = obs_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int idx = 0;
        wr_t e;
        exp_q.delete();
        exp_q.push_back(mk(K_CNF, 0, 2));
        do_start(2);
`ifdef TREE_LOADER_VALIDATE_EN
        send(32'hFFFFFFFF, 0, 0);
        repeat (6) @(negedge clk);
`else
        push_node(0, 12'h3FF, 7, 12'hFFF, 7'h7F);
        push_node(1, 0, 0, 0, 0);
        send(32'hFFFFFFFF, 0, 0);
        send(32'h00000000, 0, 0);
        wait_done(d0, "ones");
`endif
        tests++;
        if (obs_q.size() - ob !== exp_q.size()) begin
            fails++;
            $display("FAIL ones_count: got %0d writes, want %0d",
                     obs_q.size() - ob, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (ob + idx < obs_q.size()) begin
                tests++;
                if (obs_q[ob + idx] !== e) begin
                    fails++;
                    $display("FAIL ones_wr%0d: got k%0d a%h d%h, want k%0d a%h d%h",
                             idx, obs_q[ob + idx].kind, obs_q[ob + idx].addr,
                             obs_q[ob + idx].data, e.kind, e.addr, e.data);
                end
            end
            idx++;
        end
        tests++;
`ifdef TREE_LOADER_VALIDATE_EN
        if (err_cnt - e0 !== 1 || busy !== 1'b0) begin
`else
        if (err_cnt - e0 !== 0 || busy !== 1'b0) begin
`endif
            fails++;
            $display("FAIL ones_err: err pulses %0d busy %b", err_cnt - e0, busy);
        end
    endtask

    task automatic test_backpressure();
        int ob = obs_q.size();
        int d0 = done_cnt;
        int idx = 0;
        wr_t e;
        exp_q.delete();
        exp_q.push_back(mk(K_CNF, 0, 3));
        push_node(0, 0, 0, 0, 0);
        push_node(1, 0, 1, 12'h012, 7'h64);
        push_node(2, 0, 2, 12'h1FE, 7'h32);
        do_start(3);
        send(32'h00000000, 0, 0);
        send(32'h00080964, 5, 0);
        send(32'h0010FF32, 0, 0);
        wait_done(d0, "bp");
        tests++;
        if (obs_q.size() - ob !== exp_q.size()) begin
            fails++;
            $display("FAIL bp_count: got %0d writes, want %0d",
                     obs_q.size() - ob, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (ob + idx < obs_q.size()) begin
                tests++;
                if (obs_q[ob + idx] !== e) begin
                    fails++;
                    $display("FAIL bp_wr%0d: got k%0d a%h d%h, want k%0d a%h d%h",
                             idx, obs_q[ob + idx].kind, obs_q[ob + idx].addr,
                             obs_q[ob + idx].data, e.kind, e.addr, e.data);
                end
            end
            idx++;
        end
        tests++;
        if (done_cyc !== e_cyc + 21) begin
            fails++;
            $display("FAIL bp_done: done in cycle E+%0d, want E+22",
                     done_cyc - e_cyc + 1);
        end
    endtask

    task automatic test_bad_count();
        int cnts[2] = '{1, 0};
        foreach (cnts[k]) begin
            int ob = obs_q.size();
            int e0 = err_cnt;
            int b0 = busy_cnt;
            do_start(cnts[k]);
            repeat (4) @(negedge clk);
            tests++;
            if (err_cnt - e0 !== 1 || obs_q.size() !== ob || busy_cnt !== b0) begin
                fails++;
                $display("FAIL badcnt_%0d: err %0d writes %0d busy %0d, want 1 0 0",
                         cnts[k], err_cnt - e0, obs_q.size() - ob, busy_cnt - b0);
            end
        end
    endtask

    task automatic test_reset_midload();
        int ob;
        int d0;
        int idx = 0;
        wr_t e;
        do_start(3);
        send(32'h00000000, 0, 0);
        send(32'h00080964, 0, 0);
        repeat (2) @(negedge clk);
        tests++;
        if (mem_rew !== 1'b1 || mem_addr !== 10'd1) begin
            fails++;
            $display("FAIL mid_rew: rew %b addr %h, want 1 001", mem_rew, mem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.in_ready, mem_par, mem_act, mem_rew, mem_weight, mem_addr,
             mem_data, conf_nodes, conf_data, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL mid_reset: got %h, want 0",
                     {bus.in_ready, mem_par, mem_act, mem_rew, mem_weight,
                      mem_addr, mem_data, conf_nodes, conf_data, busy, done, err});
        end
        rst = 1'b0;
        ob = obs_q.size();
        d0 = done_cnt;
        exp_q.delete();
        exp_q.push_back(mk(K_CNF, 0, 2));
        push_node(0, 0, 2, 12'h1FE, 7'h32);
        push_node(1, 0, 1, 12'h012, 7'h64);
        do_start(2);
        send(32'h0010FF32, 0, 0);
        send(32'h00080964, 0, 0);
        wait_done(d0, "reload");
        tests++;
        if (obs_q.size() - ob !== exp_q.size()) begin
            fails++;
            $display("FAIL reload_count: got %0d writes, want %0d",
                     obs_q.size() - ob, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (ob + idx < obs_q.size()) begin
                tests++;
                if (obs_q[ob + idx] !== e) begin
                    fails++;
                    $display("FAIL reload_wr%0d: got k%0d a%h d%h, want k%0d a%h d%h",
                             idx, obs_q[ob + idx].kind, obs_q[ob + idx].addr,
                             obs_q[ob + idx].data, e.kind, e.addr, e.data);
                end
            end
            idx++;
        end
        tests++;
        if (done_cyc !== e_cyc + 11) begin
            fails++;
            $display("FAIL reload_done: done in cycle E+%0d, want E+12",
                     done_cyc - e_cyc + 1);
        end
    endtask

    task automatic test_validate();
        logic [31:0] bad_w[2] = '{32'h01400000, 32'h00000065};
        int          cnt[2] = '{3, 2};
        foreach (cnt[k]) begin
            int ob = obs_q.size();
            int d0 = done_cnt;
            int e0 = err_cnt;
            int idx = 0;
            int want_err = 0;
            wr_t e;
            exp_q.delete();
            exp_q.push_back(mk(K_CNF, 0, cnt[k]));
            push_node(0, 0, 0, 0, 0);
            if (cnt[k] == 3) push_node(1, 0, 1, 12'h012, 7'h64);
            do_start(cnt[k]);
            send(32'h00000000, 0, 0);
            if (cnt[k] == 3) send(32'h00080964, 0, 0);
            send(bad_w[k], 0, 0);
`ifdef TREE_LOADER_VALIDATE_EN
            want_err = 1;
            repeat (6) @(negedge clk);
`else
            if (cnt[k] == 3) push_node(2, 5, 0, 0, 0);
            else push_node(1, 0, 0, 0, 7'h65);
            wait_done(d0, "val");
`endif
            tests++;
            if (obs_q.size() - ob !== exp_q.size()) begin
                fails++;
                $display("FAIL val%0d_count: got %0d writes, want %0d",
                         k, obs_q.size() - ob, exp_q.size());
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (ob + idx < obs_q.size()) begin
                    tests++;
                    if (obs_q[ob + idx] !== e) begin
                        fails++;
                        $display("FAIL val%0d_wr%0d: got k%0d a%h d%h, want k%0d a%h d%h",
                                 k, idx, obs_q[ob + idx].kind, obs_q[ob + idx].addr,
                                 obs_q[ob + idx].data, e.kind, e.addr, e.data);
                    end
                end
                idx++;
            end
            tests++;
            if (err_cnt - e0 !== want_err || done_cnt - d0 !== 1 - want_err
                || busy !== 1'b0) begin
                fails++;
                $display("FAIL val%0d_end: err %0d done %0d busy %b, want %0d %0d 0",
                         k, err_cnt - e0, done_cnt - d0, busy, want_err, 1 - want_err);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        node_count = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        test_reset();
        test_basic();
        test_all_ones();
        test_backpressure();
        test_bad_count();
        test_reset_midload();
        test_validate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tree_loader.md
# tree_loader

Sideband transmitter that populates the tree evaluator's node buffer and configuration. It accepts a node count and a stream of packed 32-bit node words over a valid/ready handshake. It unpacks each word into parent, action, reward and weight fields and issues one single-cycle field write per field on the mem_* sideband. It sits between the host/DMA side and the tree evaluator, and is the only driver of that evaluator's mem_* and conf_* inputs.

## Interface
- W_ADDR, 10, node address width (max 1024 nodes)
- W_DATA, 12, sideband data width (widest field, the reward)
- W_CONF, 10, config data width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a load; sampled only in IDLE
- node_count  in  W_CONF  number of nodes to load, sampled with start; legal range 2..1023
- in_valid  in  1  node word valid
- in_data  in  32  packed node: parent [31:22], action [21:19], reward [18:7] (two's complement), weight [6:0]
- in_ready  out  1  node word accepted when in_valid & in_ready
- mem_par, mem_act, mem_rew, mem_weight  out  1 each  field write strobes; at most one high per cycle
- mem_addr  out  W_ADDR  node address of the current field write
- mem_data  out  W_DATA  field value, zero-extended to W_DATA
- conf_nodes  out  1  config write strobe
- conf_data  out  W_CONF  node count
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load completion
- err  out  1  one-cycle pulse on a rejected start or a rejected node

## Operation
- States: IDLE, CONF, FETCH, PAR, ACT, REW, WGT, DONE.
- IDLE:
  - start with node_count in 2..1023 → latch count, clear addr to 0, go to CONF.
  - start with an illegal node_count → err pulse, stay in IDLE.
- CONF: conf_nodes=1, conf_data=count, one cycle → FETCH.
- FETCH:
  - in_ready=1.
  - On handshake, latch in_data → PAR.
  - With no handshake, stay in FETCH; no strobes, addr held.
- PAR, ACT, REW, WGT: one cycle each, in that order.
  - The matching strobe is high, mem_addr=addr, mem_data=the field zero-extended.
  - Reward bits pass unmodified; there is no sign extension.
- After WGT:
  - If addr==count-1 → DONE.
  - Otherwise addr+1 → FETCH.
- DONE: done=1 for one cycle → IDLE.
- Node order is ascending, starting from the root at address 0. The root's parent field is written as received.
- busy=1 in every state except IDLE.
- start outside IDLE is ignored.
- All outputs are registered.
- Reset mid-load: the load is abandoned and the next cycle is IDLE with all outputs 0. Partially written nodes are left downstream; the next start reloads from address 0.

## Timing
- Reset values: in_ready, all strobes, mem_addr, mem_data, conf_nodes, conf_data, busy, done and err are all 0.
- start sampled at edge E → conf_nodes high in cycle E+1 → in_ready high from E+2.
- Handshake at edge H → mem_par in H+1, mem_act in H+2, mem_rew in H+3, mem_weight in H+4 → in_ready again in H+5.
- Minimum 5 cycles per node.
- N nodes with in_valid held high: done in cycle E+2+5N.
- in_ready is low in every state except FETCH. No word is accepted during the field writes.

## Configuration
- TREE_LOADER_VALIDATE_EN defined: each latched word is checked in PAR before any strobe.
  - The check fails if weight > 100, or if addr ≠ 0 and parent ≥ addr (a parent must precede its child).
  - On failure: no strobes for that node, err pulse, → IDLE, load aborted.
- Not defined: no checks; every word is written as received.

## Structure
- Shared package treeval_pkg holds:
  - W_ADDR, W_ACTION=3, W_REWARD=12, W_WEIGHT=7, NODE_SIZE=32, MAX_NUM_NODES=1024;
  - the field slice constants (PARENT_HI/LO, ACTION_HI/LO, REWARD_HI/LO, WEIGHT_HI/LO), shared with the tree evaluator;
  - the loader state enum typedef.
- One sub-module, tree_node_unpack: a combinational split of the 32-bit word into its four fields, plus the validation flags.

## Test plan
- count=3, words 0x00000000, 0x00080964, 0x0010FF32 streamed back-to-back:
  - conf_nodes with conf_data=3, then 12 strobes in par/act/rew/weight order for addr 0, 1, 2;
  - node 1 writes parent=0, action=1, reward=0x012, weight=0x64;
  - done in cycle E+17.
- Word 0xFFFFFFFF:
  - mem_data sequence 0x3FF, 0x007, 0xFFF, 0x07F;
  - no sign extension of the reward.
- Backpressure: in_valid low for 5 cycles before node 1 → in_ready held high, no strobes, mem_addr unchanged, done delayed by 5 cycles.
- start with count=1, and separately count=0 → err pulse, no conf_nodes, busy stays 0.
- rst during REW of node 1 → next cycle all outputs 0. A following start with count=2 → conf_data=2, writes begin at addr 0.
- With TREE_LOADER_VALIDATE_EN: node 2 with parent=5 → err, no strobes at addr 2, IDLE. Node 1 with weight=101 → err. Without the macro, both are written unchanged.
